datapath_param: RTL and testbench

DATAPATH_PARAM -- requirements
Module: datapath_param

---
 rtl/datapath_param_if.sv | 57 +++++
 rtl/datapath_param.sv | 207 ++++++++++++++++++++
 tb/tb_datapath_param.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_param_if.sv
// Control, data and status bundle between a sequencer (master) and the
// datapath_param processor datapath (slave).
interface datapath_param_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic [3:0]       bus_src;
    logic [AW-1:0]    rs_addr;
    logic [AW-1:0]    rd_addr;
    logic             rin;
    logic             baout;
    logic             pc_in;
    logic             pc_inc;
    logic             mar_in;
    logic             mdr_in;
    logic             mem_read;
    logic [WIDTH-1:0] mem_data_in;
    logic             hi_in;
    logic             lo_in;
    logic             y_in;
    logic             z_in;
    logic             ip_in;
    logic             op_in;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] input_unit;
    logic             md_start;
    logic             md_op;
    logic             md_signed;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data_out;
    logic [WIDTH-1:0] output_unit;
    logic             md_busy;
    logic             md_done;
    logic             div_by_zero;

    modport master (
        output bus_src, rs_addr, rd_addr, rin, baout, pc_in, pc_inc,
               mar_in, mdr_in, mem_read, mem_data_in, hi_in, lo_in,
               y_in, z_in, ip_in, op_in, alu_op, imm, input_unit,
               md_start, md_op, md_signed,
        input  bus, mem_addr, mem_data_out, output_unit,
               md_busy, md_done, div_by_zero
    );

    modport slave (
        input  bus_src, rs_addr, rd_addr, rin, baout, pc_in, pc_inc,
               mar_in, mdr_in, mem_read, mem_data_in, hi_in, lo_in,
               y_in, z_in, ip_in, op_in, alu_op, imm, input_unit,
               md_start, md_op, md_signed,
        output bus, mem_addr, mem_data_out, output_unit,
               md_busy, md_done, div_by_zero
    );
endinterface

// File: rtl/datapath_param.sv
// Single-bus processor datapath: register file, PC/MAR/MDR, ALU with Y/Z
// staging and an iterative multiply/divide engine writing HI/LO.
module datapath_param #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic              clock,
    input  logic              clear,
    datapath_param_if.slave   dp
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIN
    } md_state_t;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] pc, mar, mdr, hi, lo, y, z, inport, outport;
    logic [WIDTH-1:0] bus, alu_result;
    logic [SW-1:0]    sh;
    logic [SW:0]      inv_sh;

    md_state_t        state, next_state;
    logic             start_ok, start_dbz;
    logic [SW-1:0]    count;
    logic [WIDTH-1:0] acc_hi, acc_lo, mag_a, mag_b, dividend;
    logic [WIDTH-1:0] y_mag, bus_mag;
    logic             op_div, neg_q, neg_r, dbz, done_q, dbz_q;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        bus = '0;
        case (dp.bus_src)
            4'd1:    bus = (dp.baout && dp.rs_addr == '0) ? '0 : regs[dp.rs_addr];
            4'd2:    bus = pc;
            4'd3:    bus = mdr;
            4'd4:    bus = hi;
            4'd5:    bus = lo;
            4'd6:    bus = z;
            4'd7:    bus = inport;
            4'd8:    bus = dp.imm;
            default: bus = '0;
        endcase
    end

    // Rotates combine two opposite shifts; a shift by WIDTH yields zero,
    // so a rotate amount of 0 falls out naturally.
    assign sh     = bus[SW-1:0];
    assign inv_sh = (SW+1)'(WIDTH) - {1'b0, sh};

    always_comb begin
        alu_result = '0;
        case (dp.alu_op)
            4'd0:    alu_result = y + bus;
            4'd1:    alu_result = y - bus;
            4'd2:    alu_result = y & bus;
            4'd3:    alu_result = y | bus;
            4'd4:    alu_result = y >> sh;
            4'd5:    alu_result = $signed(y) >>> sh;
            4'd6:    alu_result = y << sh;
            4'd7:    alu_result = (y >> sh) | (y << inv_sh);
            4'd8:    alu_result = (y << sh) | (y >> inv_sh);
            4'd9:    alu_result = -bus;
            4'd10:   alu_result = ~bus;
            4'd11:   alu_result = bus;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pc      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            z       <= '0;
            inport  <= '0;
            outport <= '0;
        end else begin
            if (dp.rin)    regs[dp.rd_addr] <= bus;
            if (dp.pc_in)  pc <= bus;
            else if (dp.pc_inc) pc <= pc + 1'b1;
            if (dp.mar_in) mar <= bus;
            if (dp.mdr_in) mdr <= dp.mem_read ? dp.mem_data_in : bus;
            if (dp.y_in)   y <= bus;
            if (dp.z_in)   z <= alu_result;
            if (dp.ip_in)  inport <= dp.input_unit;
            if (dp.op_in)  outport <= bus;
        end
    end

    assign y_mag   = (dp.md_signed && y[WIDTH-1])   ? -y   : y;
    assign bus_mag = (dp.md_signed && bus[WIDTH-1]) ? -bus : bus;

    // A zero divisor goes straight to FIN so its result lands one cycle later.
    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        start_dbz  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (dp.md_start) begin
                    start_ok   = 1'b1;
                    start_dbz  = dp.md_op && (bus == '0);
                    next_state = start_dbz ? MD_FIN : MD_RUN;
                end
            end
            MD_RUN:  if (count == SW'(WIDTH - 1)) next_state = MD_FIN;
            MD_FIN:  next_state = MD_IDLE;
            default: next_state = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= MD_IDLE;
        else       state <= next_state;
    end

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, mag_a};
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b};
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b;

    // Unsigned shift-add / restoring-divide core on operand magnitudes;
    // signs are reapplied when the result is committed in FIN.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            dividend <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz      <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= (state == MD_FIN);
            dbz_q  <= (state == MD_FIN) && dbz;
            case (state)
                MD_IDLE: begin
                    if (start_ok) begin
                        op_div   <= dp.md_op;
                        dbz      <= start_dbz;
                        neg_q    <= dp.md_signed && (y[WIDTH-1] ^ bus[WIDTH-1]);
                        neg_r    <= dp.md_signed && y[WIDTH-1];
                        mag_a    <= y_mag;
                        mag_b    <= bus_mag;
                        dividend <= y;
                        count    <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= dp.md_op ? y_mag : bus_mag;
                    end
                end
                MD_RUN: begin
                    count <= count + 1'b1;
                    if (op_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else if (acc_lo[0]) begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end else begin
                        {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine results own HI/LO from start through the done cycle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MD_FIN) begin
            if (dbz) begin
                hi <= dividend;
                lo <= '1;
            end else if (op_div) begin
                hi <= neg_r ? -acc_hi : acc_hi;
                lo <= neg_q ? -acc_lo : acc_lo;
            end else begin
                {hi, lo} <= neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
            end
        end else if (state == MD_IDLE && !done_q) begin
            if (dp.hi_in) hi <= bus;
            if (dp.lo_in) lo <= bus;
        end
    end

    assign dp.bus          = bus;
    assign dp.mem_addr     = mar;
    assign dp.mem_data_out = mdr;
    assign dp.output_unit  = outport;
    assign dp.md_busy      = (state != MD_IDLE);
    assign dp.md_done      = done_q;
    assign dp.div_by_zero  = dbz_q;
endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param: stimulus queues expected values,
// a negedge monitor compares when an observation or md_done is presented.
module tb_datapath_param;
    localparam int WIDTH = 32;

    localparam int SEL_BUS  = 0;
    localparam int SEL_MAR  = 1;
    localparam int SEL_MDR  = 2;
    localparam int SEL_OUT  = 3;
    localparam int SEL_BUSY = 4;
    localparam int SEL_DONE = 5;
    localparam int SEL_DBZ  = 6;

    localparam int S_RIN    = 0;
    localparam int S_Y      = 1;
    localparam int S_Z      = 2;
    localparam int S_PC     = 3;
    localparam int S_PCBOTH = 4;
    localparam int S_PCINC  = 5;
    localparam int S_MAR    = 6;
    localparam int S_MDR    = 7;
    localparam int S_OP     = 8;
    localparam int S_HI     = 9;
    localparam int S_IP     = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } obs_t;

    typedef struct {
        int          cyc;
        logic        dbz;
        logic [31:0] hi;
    } md_t;

    typedef struct {
        logic [31:0] y;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } alu_vec_t;

    logic clock;
    logic clear;
    int   checks;
    int   failures;
    int   cyc;
    int   done_count;
    logic obs_req;
    obs_t obs_q[$];
    md_t  md_q[$];
    alu_vec_t alu_tab[11];

    datapath_param_if #(.WIDTH(WIDTH), .NREGS(16)) dp ();

    datapath_param #(.WIDTH(WIDTH), .NREGS(16)) dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_BUS:  return dp.bus;
            SEL_MAR:  return dp.mem_addr;
            SEL_MDR:  return dp.mem_data_out;
            SEL_OUT:  return dp.output_unit;
            SEL_BUSY: return {31'b0, dp.md_busy};
            SEL_DONE: return {31'b0, dp.md_done};
            SEL_DBZ:  return {31'b0, dp.div_by_zero};
            default:  return 32'h0;
        endcase
    endfunction

    // Monitor: compares queued observations and every md_done presentation.
    initial begin
        obs_t        e;
        md_t         m;
        logic [31:0] act;
        done_count = 0;
        forever begin
            @(negedge clock);
            if (obs_req) begin
                checks++;
                if (obs_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL obs_underflow: got empty queue required an entry");
                end else begin
                    e   = obs_q.pop_front();
                    act = pick(e.sel);
                    if (act !== e.exp) begin
                        failures++;
                        $display("[TB] FAIL %s: got %h required %h", e.name, act, e.exp);
                    end
                end
            end
            if (dp.md_done === 1'b1) begin
                done_count++;
                checks++;
                if (md_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: got md_done=1 at cycle %0d required none", cyc);
                end else begin
                    m = md_q.pop_front();
                    if (cyc != m.cyc) begin
                        failures++;
                        $display("[TB] FAIL done_cycle: got %0d required %0d", cyc, m.cyc);
                    end
                    checks++;
                    if (dp.div_by_zero !== m.dbz) begin
                        failures++;
                        $display("[TB] FAIL done_dbz: got %b required %b", dp.div_by_zero, m.dbz);
                    end
                    checks++;
                    if (dp.bus !== m.hi) begin
                        failures++;
                        $display("[TB] FAIL done_hi: got %h required %h", dp.bus, m.hi);
                    end
                    checks++;
                    if (dp.md_busy !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL done_busy: got %b required 0", dp.md_busy);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleControls();
        dp.rin      = 1'b0;
        dp.pc_in    = 1'b0;
        dp.pc_inc   = 1'b0;
        dp.mar_in   = 1'b0;
        dp.mdr_in   = 1'b0;
        dp.hi_in    = 1'b0;
        dp.lo_in    = 1'b0;
        dp.y_in     = 1'b0;
        dp.z_in     = 1'b0;
        dp.ip_in    = 1'b0;
        dp.op_in    = 1'b0;
        dp.md_start = 1'b0;
    endtask

    // Drives value onto the bus via imm and pulses one load strobe for a cycle.
    task automatic applyStimulus(input logic [31:0] value, input int strobe);
        dp.bus_src    = 4'd8;
        dp.imm        = value;
        dp.input_unit = value;
        case (strobe)
            S_RIN:    dp.rin = 1'b1;
            S_Y:      dp.y_in = 1'b1;
            S_Z:      dp.z_in = 1'b1;
            S_PC:     dp.pc_in = 1'b1;
            S_PCBOTH: begin dp.pc_in = 1'b1; dp.pc_inc = 1'b1; end
            S_PCINC:  dp.pc_inc = 1'b1;
            S_MAR:    dp.mar_in = 1'b1;
            S_MDR:    dp.mdr_in = 1'b1;
            S_OP:     dp.op_in = 1'b1;
            S_HI:     dp.hi_in = 1'b1;
            S_IP:     dp.ip_in = 1'b1;
            default:  ;
        endcase
        tick();
        idleControls();
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        obs_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        obs_q.push_back(e);
        obs_req = 1'b1;
        tick();
        obs_req = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int target;
        target = done_count + 1;
        for (int i = 0; i < 60; i++) begin
            if (done_count >= target) break;
            tick();
        end
        if (done_count < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no md_done required one within 60 cycles", name);
        end
    endtask

    task automatic runMd(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic sgn, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz, input logic interfere);
        md_t m;
        applyStimulus(a, S_Y);
        dp.bus_src   = 4'd8;
        dp.imm       = b;
        dp.md_op     = op;
        dp.md_signed = sgn;
        dp.md_start  = 1'b1;
        tick();
        dp.md_start = 1'b0;
        dp.bus_src  = 4'd4;
        m.cyc = cyc + (exp_dbz ? 1 : WIDTH + 1);
        m.dbz = exp_dbz;
        m.hi  = exp_hi;
        md_q.push_back(m);
        if (interfere) begin
            checkOutput({name, "_busy"}, SEL_BUSY, 32'd1);
            dp.bus_src  = 4'd8;
            dp.imm      = 32'h1234;
            dp.hi_in    = 1'b1;
            dp.lo_in    = 1'b1;
            dp.md_start = 1'b1;
            dp.md_op    = ~op;
            tick();
            idleControls();
            dp.md_op   = op;
            dp.bus_src = 4'd4;
        end
        waitDone(name);
        dp.bus_src = 4'd5;
        checkOutput({name, "_lo"}, SEL_BUS, exp_lo);
        if (exp_dbz) checkOutput({name, "_dbz_one_cycle"}, SEL_DBZ, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        obs_req  = 1'b0;
        clear    = 1'b1;
        idleControls();
        dp.bus_src     = 4'd0;
        dp.rs_addr     = '0;
        dp.rd_addr     = '0;
        dp.baout       = 1'b0;
        dp.mem_read    = 1'b0;
        dp.mem_data_in = '0;
        dp.alu_op      = 4'd0;
        dp.imm         = '0;
        dp.input_unit  = '0;
        dp.md_op       = 1'b0;
        dp.md_signed   = 1'b0;

        alu_tab[0]  = '{32'h80000000, 32'd4,        4'd5,  32'hF8000000};
        alu_tab[1]  = '{32'h80000000, 32'd4,        4'd4,  32'h08000000};
        alu_tab[2]  = '{32'h00000001, 32'd1,        4'd7,  32'h80000000};
        alu_tab[3]  = '{32'h80000000, 32'd1,        4'd8,  32'h00000001};
        alu_tab[4]  = '{32'h00000001, 32'd2,        4'd1,  32'hFFFFFFFF};
        alu_tab[5]  = '{32'h12345678, 32'hF0F0F0F0, 4'd2,  32'h10305070};
        alu_tab[6]  = '{32'h00000000, 32'd5,        4'd9,  32'hFFFFFFFB};
        alu_tab[7]  = '{32'h00000000, 32'h0F0F0F0F, 4'd10, 32'hF0F0F0F0};
        alu_tab[8]  = '{32'h00000001, 32'h00000021, 4'd6,  32'h00000002};
        alu_tab[9]  = '{32'h00000007, 32'd0,        4'd12, 32'h00000000};
        alu_tab[10] = '{32'h80000001, 32'd0,        4'd7,  32'h80000001};

        repeat (3) tick();
        clear = 1'b0;
        tick();

        dp.bus_src = 4'd2;
        checkOutput("reset_pc", SEL_BUS, 32'h0);
        dp.bus_src = 4'd1;
        dp.rs_addr = 4'd5;
        checkOutput("reset_reg5", SEL_BUS, 32'h0);
        checkOutput("reset_mar", SEL_MAR, 32'h0);
        checkOutput("reset_mdr", SEL_MDR, 32'h0);
        checkOutput("reset_outport", SEL_OUT, 32'h0);
        checkOutput("reset_busy", SEL_BUSY, 32'h0);
        checkOutput("reset_done", SEL_DONE, 32'h0);

        dp.rd_addr = 4'd3;
        applyStimulus(32'd5, S_RIN);
        dp.bus_src = 4'd1;
        dp.rs_addr = 4'd3;
        checkOutput("reg3_read", SEL_BUS, 32'd5);
        dp.rd_addr = 4'd0;
        applyStimulus(32'd7, S_RIN);
        dp.bus_src = 4'd1;
        dp.rs_addr = 4'd0;
        checkOutput("reg0_storage", SEL_BUS, 32'd7);
        dp.baout = 1'b1;
        checkOutput("reg0_baout_zero", SEL_BUS, 32'd0);
        dp.rs_addr = 4'd3;
        checkOutput("reg3_baout", SEL_BUS, 32'd5);
        dp.baout = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(alu_tab[i].y, S_Y);
            dp.alu_op = alu_tab[i].op;
            applyStimulus(alu_tab[i].b, S_Z);
            dp.bus_src = 4'd6;
            checkOutput($sformatf("alu_vec%0d", i), SEL_BUS, alu_tab[i].exp);
        end

        dp.mem_read    = 1'b1;
        dp.mem_data_in = 32'h0000ABCD;
        applyStimulus(32'h55, S_MDR);
        checkOutput("mdr_from_mem", SEL_MDR, 32'h0000ABCD);
        dp.mem_read = 1'b0;
        applyStimulus(32'h55, S_MDR);
        checkOutput("mdr_from_bus", SEL_MDR, 32'h55);
        applyStimulus(32'h100, S_MAR);
        checkOutput("mar_load", SEL_MAR, 32'h100);
        applyStimulus(32'h40, S_PCBOTH);
        dp.bus_src = 4'd2;
        checkOutput("pc_in_wins", SEL_BUS, 32'h40);
        applyStimulus(32'h0, S_PCINC);
        dp.bus_src = 4'd2;
        checkOutput("pc_inc", SEL_BUS, 32'h41);
        applyStimulus(32'hFFFFFFFF, S_PC);
        applyStimulus(32'h0, S_PCINC);
        dp.bus_src = 4'd2;
        checkOutput("pc_wrap", SEL_BUS, 32'h0);
        applyStimulus(32'h77, S_OP);
        checkOutput("outport", SEL_OUT, 32'h77);
        applyStimulus(32'hCAFE, S_IP);
        dp.bus_src = 4'd7;
        checkOutput("inport", SEL_BUS, 32'hCAFE);
        applyStimulus(32'h11, S_HI);
        dp.bus_src = 4'd4;
        checkOutput("hi_in_idle", SEL_BUS, 32'h11);

        runMd("smul", 32'hFFFFFFFD, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        runMd("sdiv", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        runMd("div0", 32'd9, 32'd0, 1'b1, 1'b0, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0);
        runMd("udiv", 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14, 1'b0, 1'b0);
        runMd("umul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0);

        applyStimulus(32'd5, S_Y);
        dp.bus_src   = 4'd8;
        dp.imm       = 32'd3;
        dp.md_op     = 1'b0;
        dp.md_signed = 1'b0;
        dp.md_start  = 1'b1;
        tick();
        dp.md_start = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("abort_busy", SEL_BUSY, 32'h0);
        dp.bus_src = 4'd4;
        checkOutput("abort_hi", SEL_BUS, 32'h0);
        dp.bus_src = 4'd5;
        checkOutput("abort_lo", SEL_BUS, 32'h0);
        repeat (40) tick();
        runMd("after_abort", 32'd6, 32'd7, 1'b0, 1'b0, 32'h0, 32'd42, 1'b0, 1'b0);

        repeat (3) tick();
        checks++;
        if (obs_q.size() != 0 || md_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL queues_drained: got obs=%0d md=%0d required 0 and 0",
                     obs_q.size(), md_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
